tinyqv_cpu_core: RTL and testbench

Minimal multi-cycle RV32E core, non-pipelined, one instruction in flight. Fetches 16-bit halfwords from a streaming instruction memory and issues byte/half/word loads and stores on a separate handshaked data bus. Supports a single level-sensitive interrupt, a time counter, and debug status outputs. Top-level CPU block of the tinyQV SoC.

---
 rtl/tinyqv_cpu_core.sv | 202 ++++++++++++++++++++
 tb/tb_tinyqv_cpu_core.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/tinyqv_cpu_core.sv
// tinyqv_cpu_core: multi-cycle RV32E core fetching halfwords from a streaming instruction memory
module tinyqv_cpu_core #(
    parameter logic [23:0] RESET_PC   = 24'h000000,
    parameter logic [23:0] IRQ_VECTOR = 24'h000008
) (
    input  logic        clk,
    input  logic        rst,
    output logic [23:1] instr_addr,
    output logic        instr_fetch_restart,
    output logic        instr_fetch_stall,
    input  logic        instr_fetch_started,
    input  logic        instr_fetch_stopped,
    input  logic [15:0] instr_data_in,
    input  logic        instr_ready,
    input  logic [15:0] interrupt_req,
    output logic [27:0] data_addr,
    output logic [1:0]  data_write_n,
    output logic [1:0]  data_read_n,
    output logic        data_read_complete,
    output logic [31:0] data_out,
    output logic        data_continue,
    input  logic        data_ready,
    input  logic [31:0] data_in,
    input  logic        time_pulse,
    output logic        debug_instr_complete,
    output logic        debug_instr_valid,
    output logic        debug_interrupt_pending,
    output logic        debug_branch,
    output logic        debug_early_branch,
    output logic        debug_ret,
    output logic        debug_reg_wen,
    output logic        debug_counter_0,
    output logic [3:0]  debug_rd
);
    typedef enum logic [2:0] {RESTART, WAIT_START, FETCH_LO, FETCH_HI, EXEC, MEM} state_t;
    state_t state, state_nx;
    logic [23:0] pc, mepc, pc4, target;
    logic [31:0] instr, time_q, a, b, opb, alu, sra, wb, wdata, ld, ls_addr, csr_rv, csr_wv;
    logic [31:0] rf [0:15];
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [15:0] instr_lo;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [3:0]  rd;
    logic [11:0] csr;
    logic [4:0]  sh;
    logic mie, is_lui, is_auipc, is_jal, is_jalr, is_br, is_load, is_store, is_opi, is_op, is_csr, is_mret;
    logic take, jump, wen_exec, irq_take, unused_bits;

    assign op    = instr[6:0];
    assign f3    = instr[14:12];
    assign rd    = instr[10:7];
    assign csr   = instr[31:20];
    assign a     = rf[instr[18:15]];
    assign b     = rf[instr[23:20]];
    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    assign is_lui   = op == 7'b0110111;
    assign is_auipc = op == 7'b0010111;
    assign is_jal   = op == 7'b1101111;
    assign is_jalr  = op == 7'b1100111 && f3 == 3'd0;
    assign is_br    = op == 7'b1100011;
    assign is_load  = op == 7'b0000011 && f3[1:0] != 2'b11 && f3 != 3'd6;
    assign is_store = op == 7'b0100011 && f3 < 3'd3;
    assign is_opi   = op == 7'b0010011;
    assign is_op    = op == 7'b0110011;
    assign is_csr   = op == 7'b1110011 && !f3[2] && f3[1:0] != 2'b00;
    assign is_mret  = instr == 32'h30200073;

    assign opb = is_op ? b : imm_i;
    assign sh  = opb[4:0];
    assign sra = $signed(a) >>> sh;
    assign alu = f3 == 3'd0 ? (is_op && instr[30] ? a - opb : a + opb) :
                 f3 == 3'd1 ? a << sh :
                 f3 == 3'd2 ? {31'b0, $signed(a) < $signed(opb)} :
                 f3 == 3'd3 ? {31'b0, a < opb} :
                 f3 == 3'd4 ? a ^ opb :
                 f3 == 3'd5 ? (instr[30] ? sra : a >> sh) :
                 f3 == 3'd6 ? a | opb : a & opb;

    // funct3[0] inverts each base condition; funct3 010/011 are not branches
    assign take = f3[2:1] == 2'b00 ? (a == b) ^ f3[0] :
                  f3[2:1] == 2'b10 ? ($signed(a) < $signed(b)) ^ f3[0] :
                  f3[2:1] == 2'b11 ? (a < b) ^ f3[0] : 1'b0;

    assign csr_rv = csr == 12'h300 ? {28'b0, mie, 3'b0} :
                    csr == 12'h341 ? {8'b0, mepc} :
                    csr == 12'hC01 ? time_q : 32'b0;
    assign csr_wv = f3[1:0] == 2'b01 ? a : f3[1:0] == 2'b10 ? csr_rv | a : csr_rv & ~a;

    assign pc4      = pc + 24'd4;
    assign ls_addr  = a + (is_store ? imm_s : imm_i);
    assign jump     = is_jal || is_jalr || (is_br && take) || is_mret;
    assign target   = is_jal ? pc + imm_j[23:0] :
                      is_jalr ? {ls_addr[23:1], 1'b0} :
                      is_br ? pc + imm_b[23:0] : mepc;
    assign wen_exec = is_lui || is_auipc || is_jal || is_jalr || is_csr || is_opi || is_op;
    assign wb       = is_lui ? imm_u :
                      is_auipc ? {8'b0, pc} + imm_u :
                      (is_jal || is_jalr) ? {8'b0, pc4} :
                      is_csr ? csr_rv : alu;
    assign ld       = f3[1:0] == 2'b00 ? {{24{data_in[7] & ~f3[2]}}, data_in[7:0]} :
                      f3[1:0] == 2'b01 ? {{16{data_in[15] & ~f3[2]}}, data_in[15:0]} : data_in;

    assign instr_addr              = pc[23:1];
    assign instr_fetch_restart     = state == RESTART && !rst;
    assign instr_fetch_stall       = state == EXEC || state == MEM;
    assign data_continue           = 1'b0;
    assign debug_instr_valid       = state == EXEC || state == MEM;
    assign debug_interrupt_pending = |interrupt_req & mie;
    assign debug_early_branch      = 1'b0;
    assign debug_counter_0         = time_q[0];
    assign debug_rd                = rd;
    assign unused_bits = &{instr_fetch_stopped, ls_addr[31:28], csr_wv[31:24], csr_wv[2:0],
                           imm_b[31:24], imm_j[31:24]};

    always_comb begin
        state_nx             = state;
        debug_branch         = 1'b0;
        debug_ret            = 1'b0;
        debug_instr_complete = 1'b0;
        debug_reg_wen        = 1'b0;
        data_read_complete   = 1'b0;
        irq_take             = 1'b0;
        wdata                = wb;
        case (state)
            RESTART:    state_nx = instr_fetch_started ? FETCH_LO : WAIT_START;
            WAIT_START: state_nx = instr_fetch_started ? FETCH_LO : WAIT_START;
            FETCH_LO: begin
                irq_take     = debug_interrupt_pending;
                debug_branch = debug_interrupt_pending;
                state_nx     = debug_interrupt_pending ? RESTART : instr_ready ? FETCH_HI : FETCH_LO;
            end
            FETCH_HI:   state_nx = instr_ready ? EXEC : FETCH_HI;
            EXEC: begin
                if (is_load || is_store) begin
                    state_nx = MEM;
                end else begin
                    debug_instr_complete = 1'b1;
                    debug_reg_wen        = wen_exec && rd != 4'd0;
                    debug_branch         = jump;
                    debug_ret            = is_mret;
                    state_nx             = jump ? RESTART : FETCH_LO;
                end
            end
            MEM: begin
                debug_instr_complete = data_ready;
                data_read_complete   = data_ready && is_load;
                debug_reg_wen        = data_ready && is_load && rd != 4'd0;
                wdata                = ld;
                state_nx             = data_ready ? FETCH_LO : MEM;
            end
            default:    state_nx = RESTART;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RESTART;
            pc           <= RESET_PC;
            mepc         <= 24'b0;
            mie          <= 1'b0;
            time_q       <= 32'b0;
            instr        <= 32'b0;
            instr_lo     <= 16'b0;
            data_addr    <= 28'b0;
            data_out     <= 32'b0;
            data_write_n <= 2'b11;
            data_read_n  <= 2'b11;
            for (int i = 0; i < 16; i++) rf[i] <= 32'b0;
        end else begin
            state  <= state_nx;
            time_q <= time_q + {31'b0, time_pulse};
            if (state == FETCH_LO && instr_ready) instr_lo <= instr_data_in;
            if (state == FETCH_HI && instr_ready) instr <= {instr_data_in, instr_lo};
            if (debug_reg_wen) rf[rd] <= wdata;
            if (debug_instr_complete) pc <= debug_branch ? target : pc4;
            if (irq_take) begin
                mepc <= pc;
                mie  <= 1'b0;
                pc   <= IRQ_VECTOR;
            end
            if (state == EXEC && is_mret) mie <= 1'b1;
            if (state == EXEC && is_csr && csr == 12'h300) mie <= csr_wv[3];
            if (state == EXEC && is_csr && csr == 12'h341) mepc <= csr_wv[23:0];
            if (state == EXEC && (is_load || is_store)) begin
                data_addr    <= ls_addr[27:0];
                data_out     <= is_store ? b : data_out;
                data_write_n <= is_store ? f3[1:0] : 2'b11;
                data_read_n  <= is_load ? f3[1:0] : 2'b11;
            end
            if (state == MEM && data_ready) begin
                data_write_n <= 2'b11;
                data_read_n  <= 2'b11;
            end
        end
    end
endmodule

// File: tb/tb_tinyqv_cpu_core.sv
// tb_tinyqv_cpu_core: directed-program bench with hand-encoded instructions and expected bus values
module tb_tinyqv_cpu_core;
    logic        clk, rst;
    logic [23:1] instr_addr;
    logic        instr_fetch_restart, instr_fetch_stall, instr_fetch_started, instr_fetch_stopped;
    logic [15:0] instr_data_in, interrupt_req;
    logic        instr_ready;
    logic [27:0] data_addr;
    logic [1:0]  data_write_n, data_read_n;
    logic        data_read_complete, data_continue, data_ready, time_pulse;
    logic [31:0] data_out, data_in;
    logic        debug_instr_complete, debug_instr_valid, debug_interrupt_pending, debug_branch;
    logic        debug_early_branch, debug_ret, debug_reg_wen, debug_counter_0;
    logic [3:0]  debug_rd;
    int tests = 0;
    int fails = 0;

    tinyqv_cpu_core dut (
        .clk(clk), .rst(rst),
        .instr_addr(instr_addr), .instr_fetch_restart(instr_fetch_restart),
        .instr_fetch_stall(instr_fetch_stall), .instr_fetch_started(instr_fetch_started),
        .instr_fetch_stopped(instr_fetch_stopped), .instr_data_in(instr_data_in),
        .instr_ready(instr_ready), .interrupt_req(interrupt_req),
        .data_addr(data_addr), .data_write_n(data_write_n), .data_read_n(data_read_n),
        .data_read_complete(data_read_complete), .data_out(data_out),
        .data_continue(data_continue), .data_ready(data_ready), .data_in(data_in),
        .time_pulse(time_pulse),
        .debug_instr_complete(debug_instr_complete), .debug_instr_valid(debug_instr_valid),
        .debug_interrupt_pending(debug_interrupt_pending), .debug_branch(debug_branch),
        .debug_early_branch(debug_early_branch), .debug_ret(debug_ret),
        .debug_reg_wen(debug_reg_wen), .debug_counter_0(debug_counter_0), .debug_rd(debug_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic restart_seq(input logic [23:1] exp_addr, input string tag);
        int n = 0;
        while (!instr_fetch_restart && n < 20) begin
            step;
            n++;
        end
        check({tag, "_restart"}, 32'(instr_fetch_restart), 32'd1);
        check({tag, "_addr"}, 32'(instr_addr), 32'(exp_addr));
        step;
        check({tag, "_pulse"}, 32'(instr_fetch_restart), 32'd0);
        instr_fetch_started = 1'b1;
        step;
        instr_fetch_started = 1'b0;
    endtask

    task automatic feed(input logic [31:0] w);
        instr_ready   = 1'b1;
        instr_data_in = w[15:0];
        step;
        instr_data_in = w[31:16];
        step;
        instr_ready   = 1'b0;
    endtask

    task automatic store(input string tag, input logic [1:0] sz, input logic [27:0] addr, input logic [31:0] d);
        step;
        check({tag, "_wr"}, 32'(data_write_n), 32'(sz));
        check({tag, "_rd"}, 32'(data_read_n), 32'd3);
        check({tag, "_addr"}, 32'(data_addr), 32'(addr));
        check({tag, "_data"}, data_out, d);
        data_ready = 1'b1;
        #1;
        check({tag, "_done"}, 32'(debug_instr_complete), 32'd1);
        step;
        data_ready = 1'b0;
        check({tag, "_idle"}, 32'(data_write_n), 32'd3);
    endtask

    task automatic load(input string tag, input logic [1:0] sz, input logic [27:0] addr,
                        input logic [31:0] din, input logic [3:0] rd);
        step;
        check({tag, "_rd"}, 32'(data_read_n), 32'(sz));
        check({tag, "_addr"}, 32'(data_addr), 32'(addr));
        data_in    = din;
        data_ready = 1'b1;
        #1;
        check({tag, "_cmpl"}, 32'(data_read_complete), 32'd1);
        check({tag, "_wen"}, 32'(debug_reg_wen), 32'd1);
        check({tag, "_dst"}, 32'(debug_rd), 32'(rd));
        step;
        data_ready = 1'b0;
        check({tag, "_idle"}, 32'(data_read_n), 32'd3);
        check({tag, "_cmpl0"}, 32'(data_read_complete), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        instr_fetch_started = 1'b0;
        instr_fetch_stopped = 1'b0;
        instr_data_in = 16'h0;
        instr_ready = 1'b0;
        interrupt_req = 16'h0;
        data_ready = 1'b0;
        data_in = 32'h0;
        time_pulse = 1'b0;
        repeat (3) step;
        check("rst_restart", 32'(instr_fetch_restart), 32'd0);
        check("rst_iaddr", 32'(instr_addr), 32'd0);
        check("rst_stall", 32'(instr_fetch_stall), 32'd0);
        check("rst_wr", 32'(data_write_n), 32'd3);
        check("rst_rdn", 32'(data_read_n), 32'd3);
        check("rst_daddr", 32'(data_addr), 32'd0);
        check("rst_dout", data_out, 32'd0);
        check("rst_valid", 32'(debug_instr_valid), 32'd0);
        check("rst_cnt0", 32'(debug_counter_0), 32'd0);
        rst = 1'b0;
        #1;
        restart_seq(23'd0, "boot");

        feed(32'h00500093);
        check("addi_wen", 32'(debug_reg_wen), 32'd1);
        check("addi_rd", 32'(debug_rd), 32'd1);
        check("addi_cmpl", 32'(debug_instr_complete), 32'd1);
        check("addi_stall", 32'(instr_fetch_stall), 32'd1);
        step;
        check("fetch_stall", 32'(instr_fetch_stall), 32'd0);
        feed(32'h00102223); store("sw_x1", 2'b10, 28'd4, 32'd5);
        feed(32'h00402103); load("lw", 2'b10, 28'd4, 32'd5, 4'd2);
        feed(32'h00202423); store("sw_x2", 2'b10, 28'd8, 32'd5);
        feed(32'h00000183); load("lb", 2'b00, 28'd0, 32'h000000F0, 4'd3);
        feed(32'h00004203); load("lbu", 2'b00, 28'd0, 32'h000000F0, 4'd4);
        feed(32'h00302023); store("sx_lb", 2'b10, 28'd0, 32'hFFFFFFF0);
        feed(32'h00402023); store("sx_lbu", 2'b10, 28'd0, 32'h000000F0);
        feed(32'h004080A3); store("sb", 2'b00, 28'd6, 32'h000000F0);
        feed(32'h401002B3); step;
        feed(32'h4012D313); step;
        feed(32'h00602023); store("srai", 2'b10, 28'd0, 32'hFFFFFFFD);
        feed(32'h00001863);
        check("bne_branch", 32'(debug_branch), 32'd0);
        check("bne_cmpl", 32'(debug_instr_complete), 32'd1);
        step;
        check("bne_norestart", 32'(instr_fetch_restart), 32'd0);

        feed(32'h00102223);
        step;
        check("abort_busy", 32'(data_write_n), 32'd2);
        rst = 1'b1;
        step;
        check("abort_wr", 32'(data_write_n), 32'd3);
        check("abort_addr", 32'(data_addr), 32'd0);
        rst = 1'b0;
        #1;
        restart_seq(23'd0, "rst2");

        feed(32'h00000863);
        check("beq_branch", 32'(debug_branch), 32'd1);
        check("beq_ret", 32'(debug_ret), 32'd0);
        restart_seq(23'd8, "beq");
        feed(32'h008000EF);
        check("jal_branch", 32'(debug_branch), 32'd1);
        check("jal_wen", 32'(debug_reg_wen), 32'd1);
        restart_seq(23'd12, "jal");
        feed(32'h00102023); store("link", 2'b10, 28'd0, 32'd20);

        feed(32'h00800293); step;
        feed(32'h3002A073);
        check("csrrs_x0_wen", 32'(debug_reg_wen), 32'd0);
        interrupt_req = 16'h0008;
        #1;
        check("irq_masked", 32'(debug_interrupt_pending), 32'd0);
        step;
        check("irq_pending", 32'(debug_interrupt_pending), 32'd1);
        check("irq_branch", 32'(debug_branch), 32'd1);
        restart_seq(23'd4, "irq");
        interrupt_req = 16'h0;
        feed(32'h34102373);
        check("mepc_rd", 32'(debug_rd), 32'd6);
        step;
        feed(32'h00602023); store("mepc", 2'b10, 28'd0, 32'd36);
        feed(32'h300023F3); step;
        feed(32'h00702023); store("mie_off", 2'b10, 28'd0, 32'd0);
        feed(32'h30200073);
        check("mret_ret", 32'(debug_ret), 32'd1);
        check("mret_branch", 32'(debug_branch), 32'd1);
        restart_seq(23'd18, "mret");
        feed(32'h300023F3); step;
        feed(32'h00702023); store("mie_on", 2'b10, 28'd0, 32'd8);

        time_pulse = 1'b1;
        repeat (3) step;
        time_pulse = 1'b0;
        check("time_bit0", 32'(debug_counter_0), 32'd1);
        feed(32'hC01021F3);
        check("time_rd", 32'(debug_rd), 32'd3);
        step;
        feed(32'h00302023); store("time", 2'b10, 28'd0, 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
